pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
Parametrised next-generation program counter for the RAT CPU. It adds a hardware return-address stack, so CALL and RET complete in one cycle without scratch-RAM traffic. It sits between the control unit (which issues PC_LD/PC_INC/PC_CALL/PC_RET) and the program ROM address bus (PC_COUNT). Stack over/underflow is reported to the interrupt/fault logic.

Parameters:
WIDTH, 10, PC and address width in bits
DEPTH, 8, return-stack entries (power of two, 2..64)
RESET_VEC, 0, PC value after reset (WIDTH bits)
INC_STEP, 1, amount added on increment and used for return address

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
DIN  in  WIDTH  load/branch target
PC_LD  in  1  load DIN into PC
PC_INC  in  1  increment PC by INC_STEP
PC_CALL  in  1  push return address, jump to DIN
PC_RET  in  1  pop top of stack into PC
ERR_CLR  in  1  clear sticky STACK_ERR
PC_COUNT  out  WIDTH  current PC (registered)
RET_TOP  out  WIDTH  current top-of-stack entry (0 when empty)
STACK_CNT  out  $clog2(DEPTH)+1  number of valid entries
STACK_EMPTY  out  1  STACK_CNT == 0
STACK_FULL  out  1  STACK_CNT == DEPTH
STACK_ERR  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (RST_N low, async, takes effect immediately): PC_COUNT=RESET_VEC, STACK_CNT=0, STACK_ERR=0, RET_TOP=0, EMPTY=1, FULL=0. Stack RAM contents are not reset.
- All state updates occur on the rising CLK edge. Single-cycle latency: the command sampled at edge N is visible on PC_COUNT after edge N.
- Command priority per cycle: PC_RET > PC_CALL > PC_LD > PC_INC > hold. Only the highest asserted command acts; the others are ignored that cycle.
- INC: PC <= PC + INC_STEP, modulo 2^WIDTH. The all-ones value wraps to INC_STEP-1.
- LD: PC <= DIN.
- CALL, not full: push (PC + INC_STEP) mod 2^WIDTH, then PC <= DIN, STACK_CNT+1.
- CALL, full: PC <= DIN anyway, no push, STACK_CNT unchanged, STACK_ERR <= 1.
- RET, not empty: PC <= top entry, STACK_CNT-1.
- RET, empty: PC holds, STACK_ERR <= 1.
- ERR_CLR clears STACK_ERR on the edge. If an error event occurs in the same cycle, set wins.
- RET_TOP, STACK_EMPTY, STACK_FULL and STACK_CNT are derived from registered state only, with no combinational path from the inputs.
- Stack is a LIFO indexed by STACK_CNT. The write pointer never wraps; the full condition is blocked rather than overwriting.
- Reset asserted mid-operation aborts any command in progress. The first edge after RST_N rises executes normally.

Decomposition:
- Package pc_pkg:
  - typedef enum pc_op_e {OP_HOLD, OP_INC, OP_LD, OP_CALL, OP_RET}.
  - Priority-decode function from the four command bits to pc_op_e.
- Sub-module ret_stack (parameters WIDTH, DEPTH): push/pop/top/count/empty/full, async active-low reset of count only.
- pc_call_stack instantiates ret_stack and holds the PC register, the next-PC mux and the error flag.

Test Plan:
1. Reset, then PC_LD with DIN=21 -> PC_COUNT=21, STACK_EMPTY=1. Then PC_LD=1, PC_INC=1, DIN=40 -> PC_COUNT=40 (LD beats INC).
2. PC=40, PC_CALL with DIN=100 -> PC_COUNT=100, RET_TOP=41, STACK_CNT=1. Then PC_RET -> PC_COUNT=41, STACK_EMPTY=1.
3. DEPTH=8: nine consecutive CALLs from PC=0 with DIN=0..8 -> STACK_FULL after the 8th, STACK_ERR=1 after the 9th, STACK_CNT=8, PC_COUNT=8. Eight RETs then pop in LIFO order.
4. Empty stack, PC=5, PC_RET -> PC_COUNT stays 5, STACK_ERR=1. Then ERR_CLR -> STACK_ERR=0. ERR_CLR together with an underflow -> STACK_ERR remains 1.
5. Wrap-around, PC=1023 (WIDTH=10): PC_INC -> PC_COUNT=0. PC_CALL with DIN=7 -> RET_TOP=0.
6. Push 3 entries, assert RST_N low between edges -> PC_COUNT=RESET_VEC and STACK_CNT=0 immediately, without waiting for an edge. Then PC_RET -> underflow, STACK_ERR=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared command encoding and decode for the call-stack program counter.
// Latency: purely combinational helpers, no state.
// Backpressure: none; the decode is evaluated every cycle.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  // Fixed command priority: RET > CALL > LD > INC > HOLD.
  function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                       input logic ld,  input logic inc);
    pc_op_e op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (ld)   op = OP_LD;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_call_stack_ret_stack.sv
// LIFO return-address stack indexed by the entry count; only the count is reset.
// Latency: push/pop take effect on the next rising edge; top/flags come from registered state.
// Backpressure: a push when full or a pop when empty is ignored and the caller flags the error.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    cnt_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    top_idx;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign cnt_o   = cnt_q;
  assign top_idx = cnt_q - CW'(1);
  // An empty stack reports zero rather than whatever stale entry sits below.
  assign top_o   = empty_o ? '0 : mem_q[top_idx[AW-1:0]];

  // Next count: blocked push/pop leave the pointer alone, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !empty_o) cnt_d = cnt_q - CW'(1);
  end

  // Count register, the only stack state cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Entry storage, written at the slot just above the current top.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[cnt_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack for single-cycle CALL/RET.
// Latency: command sampled at an edge is visible on PC_COUNT right after that edge.
// Backpressure: none; stack overflow/underflow sets the sticky STACK_ERR instead.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC_STEP  = 1,
  localparam int              CW        = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             PC_LD,
  input  logic             PC_INC,
  input  logic             PC_CALL,
  input  logic             PC_RET,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] PC_COUNT,
  output logic [WIDTH-1:0] RET_TOP,
  output logic [CW-1:0]    STACK_CNT,
  output logic             STACK_EMPTY,
  output logic             STACK_FULL,
  output logic             STACK_ERR
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             err_q, err_d;
  logic             err_set;
  logic             push, pop;

  assign op     = pc_decode(PC_RET, PC_CALL, PC_LD, PC_INC);
  // Increment and return address share the same modulo-2^WIDTH sum.
  assign pc_inc = pc_q + STEP;

  ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ret_stack (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .push_i     (push),
    .push_dat_i (pc_inc),
    .pop_i      (pop),
    .top_o      (RET_TOP),
    .cnt_o      (STACK_CNT),
    .empty_o    (STACK_EMPTY),
    .full_o     (STACK_FULL)
  );

  // Next-PC mux and stack control; CALL still jumps when the stack is full.
  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    unique case (op)
      OP_INC:  pc_d = pc_inc;
      OP_LD:   pc_d = DIN;
      OP_CALL: begin
        pc_d    = DIN;
        push    = !STACK_FULL;
        err_set = STACK_FULL;
      end
      OP_RET: begin
        if (STACK_EMPTY) begin
          err_set = 1'b1;
        end else begin
          pc_d = RET_TOP;
          pop  = 1'b1;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // A fresh error in the same cycle as ERR_CLR keeps the flag set.
  assign err_d = err_set | (err_q & ~ERR_CLR);

  // PC and sticky error registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign PC_COUNT  = pc_q;
  assign STACK_ERR = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
module tb_pc_call_stack;

  localparam int W     = 10;
  localparam int D     = 8;
  localparam int CW    = $clog2(D) + 1;
  localparam int RVEC  = 0;
  localparam int STEPV = 1;
  localparam int MODV  = 1 << W;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [W-1:0]  DIN;
  logic          PC_LD, PC_INC, PC_CALL, PC_RET, ERR_CLR;
  logic [W-1:0]  PC_COUNT, RET_TOP;
  logic [CW-1:0] STACK_CNT;
  logic          STACK_EMPTY, STACK_FULL, STACK_ERR;

  int checks   = 0;
  int failures = 0;

  // reference model: plain integers and a queue used as a LIFO
  int m_pc;
  int m_err;
  int m_stk[$];

  typedef struct {
    logic ret, call, ld, inc, clr;
    int   din;
    int   pc, cnt, top, err;
  } vec_t;

  vec_t vecs[$];

  pc_call_stack #(
    .WIDTH(W), .DEPTH(D), .RESET_VEC(W'(RVEC)), .INC_STEP(STEPV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN),
    .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_CALL(PC_CALL), .PC_RET(PC_RET),
    .ERR_CLR(ERR_CLR), .PC_COUNT(PC_COUNT), .RET_TOP(RET_TOP),
    .STACK_CNT(STACK_CNT), .STACK_EMPTY(STACK_EMPTY),
    .STACK_FULL(STACK_FULL), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic ret, logic call, logic ld, logic inc, logic clr,
                              int din, int pc, int cnt, int top, int err);
    vec_t v;
    v.ret = ret; v.call = call; v.ld = ld; v.inc = inc; v.clr = clr;
    v.din = din; v.pc = pc; v.cnt = cnt; v.top = top; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input logic ret, input logic call, input logic ld,
                            input logic inc, input logic clr, input int din);
    int fault = 0;
    if (ret) begin
      if (m_stk.size() == 0) fault = 1;
      else m_pc = m_stk.pop_back();
    end else if (call) begin
      if (m_stk.size() == D) fault = 1;
      else m_stk.push_back((m_pc + STEPV) % MODV);
      m_pc = din;
    end else if (ld) begin
      m_pc = din;
    end else if (inc) begin
      m_pc = (m_pc + STEPV) % MODV;
    end
    if (fault) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic check_model(input string nm);
    int sz = m_stk.size();
    chk({nm, " pc"},    32'(PC_COUNT),    32'(m_pc));
    chk({nm, " cnt"},   32'(STACK_CNT),   32'(sz));
    chk({nm, " top"},   32'(RET_TOP),     sz > 0 ? 32'(m_stk[sz-1]) : 32'd0);
    chk({nm, " empty"}, 32'(STACK_EMPTY), 32'(sz == 0));
    chk({nm, " full"},  32'(STACK_FULL),  32'(sz == D));
    chk({nm, " err"},   32'(STACK_ERR),   32'(m_err));
  endtask

  task automatic step(input logic ret, input logic call, input logic ld,
                      input logic inc, input logic clr, input int din);
    @(negedge CLK);
    PC_RET = ret; PC_CALL = call; PC_LD = ld; PC_INC = inc; ERR_CLR = clr;
    DIN = W'(din);
    model_step(ret, call, ld, inc, clr, din);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    PC_RET = 0; PC_CALL = 0; PC_LD = 0; PC_INC = 0; ERR_CLR = 0; DIN = '0;
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    PC_RET = 0; PC_CALL = 0; PC_LD = 0; PC_INC = 0; ERR_CLR = 0; DIN = '0;
    model_reset();

    // directed table: {ret,call,ld,inc,clr,din} -> {pc,cnt,top,err}
    vecs.push_back(mk(0,0,1,0,0,  21,   21,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,  40,   40,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 100,  100,1,41,0));
    vecs.push_back(mk(1,0,0,0,0,   0,   41,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,   5,    5,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,   0,    5,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,   0,    5,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,   0,    5,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,   0,    5,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1023, 1023,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,   0,    0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1023, 1023,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,   7,    7,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   0,    0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,   9,    0,0,0,1));
    vecs.push_back(mk(0,1,1,1,1,   9,    9,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,   0,    1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 300,    1,0,0,0));

    // reset state is visible before any clock edge
    #1;
    check_model("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ret, vecs[i].call, vecs[i].ld, vecs[i].inc, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d pc", i),  32'(PC_COUNT),  32'(vecs[i].pc));
      chk($sformatf("vec%0d cnt", i), 32'(STACK_CNT), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d top", i), 32'(RET_TOP),   32'(vecs[i].top));
      chk($sformatf("vec%0d err", i), 32'(STACK_ERR), 32'(vecs[i].err));
    end

    // nine calls into a depth-8 stack, then eight LIFO returns
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 0, 0, 0, k);
      check_model($sformatf("fill%0d", k));
      if (k == 7) chk("full after 8th", 32'(STACK_FULL), 32'd1);
    end
    chk("ovf err",  32'(STACK_ERR), 32'd1);
    chk("ovf cnt",  32'(STACK_CNT), 32'd8);
    chk("ovf pc",   32'(PC_COUNT),  32'd8);
    begin
      int pops[8] = '{7, 6, 5, 4, 3, 2, 1, 1};
      for (int k = 0; k < 8; k++) begin
        step(1, 0, 0, 0, 0, 0);
        chk($sformatf("pop%0d pc", k), 32'(PC_COUNT), 32'(pops[k]));
        check_model($sformatf("pop%0d", k));
      end
    end
    chk("drained empty", 32'(STACK_EMPTY), 32'd1);

    // asynchronous reset mid-operation with a partly filled stack
    do_reset();
    step(0, 0, 1, 0, 0, 50);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 200 + k);
      check_model($sformatf("pre%0d", k));
    end
    @(negedge CLK);
    PC_CALL = 0; PC_LD = 0;
    #2 RST_N = 1'b0;
    #1;
    chk("async pc",    32'(PC_COUNT),    32'(RVEC));
    chk("async cnt",   32'(STACK_CNT),   32'd0);
    chk("async empty", 32'(STACK_EMPTY), 32'd1);
    chk("async top",   32'(RET_TOP),     32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    chk("post-reset underflow err", 32'(STACK_ERR), 32'd1);
    check_model("post-reset");

    // randomized commands against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int  bias = (i < 300) ? 3 : 5;
      logic r, c, l, n, e;
      r = ($urandom_range(0, bias) == 0);
      c = ($urandom_range(0, 8 - bias) == 0);
      l = ($urandom_range(0, 5) == 0);
      n = ($urandom_range(0, 1) == 0);
      e = ($urandom_range(0, 7) == 0);
      step(r, c, l, n, e, int'($urandom_range(0, MODV - 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
